// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, then releases them
// one by one after per-domain delays; software can restart the sequence.
module rst_seq_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_DOM*CNT_W-1:0] dly_cfg,
  input  logic                     sw_rst_req,
  output logic                     sw_rst_ack,
  output logic [NUM_DOM-1:0]       rst_n_o,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int CW1   = CNT_W + 1;

  localparam logic [CNT_W:0]   HOLD_LAST = CW1'(HOLD_CYC - 1);
  localparam logic [CNT_W:0]   CNT_ONE   = CW1'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]               state;
  logic [CNT_W:0]           cnt;
  logic [IDX_W-1:0]         idx;
  logic [NUM_DOM*CNT_W-1:0] shadow;
  logic [CNT_W-1:0]         cur_dly;
  logic                     stage_end;
  logic                     accept;

  assign cur_dly   = shadow[idx*CNT_W +: CNT_W];
  assign stage_end = (cnt == {1'b0, cur_dly});
  assign accept    = sw_rst_req && (state != S_ASSERT);
  assign busy      = ~done;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      rst_n_o    <= '0;
      sw_rst_ack <= 1'b0;
      done       <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      if (accept) begin
        state      <= S_ASSERT;
        cnt        <= '0;
        idx        <= '0;
        rst_n_o    <= '0;
        sw_rst_ack <= 1'b1;
        done       <= 1'b0;
      end else begin
        case (state)
          S_ASSERT: begin
            if (cnt == HOLD_LAST) begin
              shadow <= dly_cfg;
              cnt    <= '0;
              idx    <= '0;
              state  <= S_RELEASE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_RELEASE: begin
            if (stage_end) begin
              rst_n_o[idx] <= 1'b1;
              cnt          <= '0;
              if (idx == IDX_LAST) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                idx <= idx + IDX_ONE;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_ASSERT;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: edge-arithmetic reference model checked
// every cycle, plus literal timing pins from the reference scenarios.
module tb_rst_seq_ctrl;

  localparam int ND   = 4;
  localparam int CW   = 8;
  localparam int HOLD = 4;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [ND*CW-1:0] dly_cfg = '0;
  logic             sw_rst_req = 1'b0;
  logic             sw_rst_ack;
  logic [ND-1:0]    rst_n_o;
  logic             busy;
  logic             done;

  rst_seq_ctrl #(.NUM_DOM(ND), .CNT_W(CW), .HOLD_CYC(HOLD)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .dly_cfg(dly_cfg),
    .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack),
    .rst_n_o(rst_n_o),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: n = edges since reset release, seq_start = edge that
  // entered ASSERT, rel[i] = absolute edge where domain i releases.
  int   n;
  int   seq_start;
  int   rel[ND];
  logic ack_exp;

  int      rise[ND];
  int      done_edge;
  int      ack_cnt;
  logic [ND-1:0] prev_rst;
  logic    prev_done;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [ND-1:0] exp_rst();
    logic [ND-1:0] e;
    e = '0;
    if (n - seq_start >= HOLD)
      for (int i = 0; i < ND; i++) e[i] = (n >= rel[i]);
    return e;
  endfunction

  task automatic clear_marks();
    for (int i = 0; i < ND; i++) rise[i] = -1;
    done_edge = -1;
    ack_cnt   = 0;
  endtask

  task automatic cycle();
    logic [ND-1:0] er;
    int acc;
    @(posedge clk);
    if (arst_n) begin
      n++;
      ack_exp = 1'b0;
      if (sw_rst_req && (n - 1 - seq_start) >= HOLD) begin
        seq_start = n;
        ack_exp   = 1'b1;
      end else if (n - seq_start == HOLD) begin
        acc = n;
        for (int i = 0; i < ND; i++) begin
          acc    = acc + int'(dly_cfg[i*CW +: CW]) + 1;
          rel[i] = acc;
        end
      end
    end
    @(negedge clk);
    er = exp_rst();
    chk("rst_n_o", 32'(rst_n_o), 32'(er));
    chk("sw_rst_ack", 32'(sw_rst_ack), 32'(ack_exp));
    chk("done", 32'(done), 32'(&er));
    chk("busy", 32'(busy), 32'(~&er));
    for (int i = 0; i < ND; i++)
      if (rst_n_o[i] && !prev_rst[i]) rise[i] = n;
    if (done && !prev_done) done_edge = n;
    if (sw_rst_ack) ack_cnt++;
    prev_rst  = rst_n_o;
    prev_done = done;
  endtask

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_rst_n_o", 32'(rst_n_o), 32'd0);
    chk("rst_ack", 32'(sw_rst_ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    n         = 0;
    seq_start = 0;
    ack_exp   = 1'b0;
    prev_rst  = '0;
    prev_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  localparam logic [ND*CW-1:0] CFG_A = 32'h0103_0002;

  int ofs[ND];
  int a;

  initial begin
    ofs[0] = 7; ofs[1] = 8; ofs[2] = 12; ofs[3] = 14;
    for (int i = 0; i < ND; i++) rel[i] = 0;

    // Power-up sequence; config scrambled after capture.
    dly_cfg = CFG_A;
    @(negedge clk);
    do_reset();
    clear_marks();
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (n == 5) dly_cfg = '1;
    end
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("pwr_rise%0d", i), 32'(rise[i]), 32'(ofs[i]));
      chk($sformatf("model_rel%0d", i), 32'(rel[i]), 32'(ofs[i]));
    end
    chk("pwr_done_edge", 32'(done_edge), 32'd14);

    // Single-cycle software request from DONE.
    dly_cfg = CFG_A;
    clear_marks();
    sw_rst_req = 1'b1;
    cycle();
    a = n;
    sw_rst_req = 1'b0;
    chk("sw_ack_seen", 32'(ack_cnt), 32'd1);
    chk("sw_rst_zero", 32'(rst_n_o), 32'd0);
    chk("sw_busy", 32'(busy), 32'd1);
    repeat (16) cycle();
    for (int i = 0; i < ND; i++)
      chk($sformatf("sw_rise%0d", i), 32'(rise[i] - a), 32'(ofs[i]));
    chk("sw_done_ofs", 32'(done_edge - a), 32'd14);
    chk("sw_ack_once", 32'(ack_cnt), 32'd1);

    // Request during ASSERT at counter 2 is ignored.
    clear_marks();
    sw_rst_req = 1'b1;
    cycle();
    a = n;
    sw_rst_req = 1'b0;
    cycle();
    cycle();
    sw_rst_req = 1'b1;
    cycle();
    sw_rst_req = 1'b0;
    repeat (14) cycle();
    chk("asrt_ack_cnt", 32'(ack_cnt), 32'd1);
    chk("asrt_rise0", 32'(rise[0] - a), 32'd7);
    chk("asrt_done_ofs", 32'(done_edge - a), 32'd14);

    // Request held high: one ack per ASSERT entry, nothing released.
    clear_marks();
    sw_rst_req = 1'b1;
    repeat (40) cycle();
    sw_rst_req = 1'b0;
    chk("hold_ack_cnt", 32'(ack_cnt), 32'd8);
    chk("hold_no_rise0", 32'(rise[0]), 32'hFFFF_FFFF);
    chk("hold_no_done", 32'(done_edge), 32'hFFFF_FFFF);
    repeat (20) cycle();
    chk("hold_recover", 32'(done), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0)
        for (int i = 0; i < ND; i++)
          dly_cfg[i*CW +: CW] = CW'($urandom_range(0, 5));
      sw_rst_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle();
    end
    sw_rst_req = 1'b0;

    // Async reset after domain 1 releases, then all-0xFF run.
    dly_cfg = CFG_A;
    do_reset();
    clear_marks();
    for (int k = 0; k < 50 && rise[1] < 0; k++) cycle();
    chk("ar_rise1", 32'(rise[1]), 32'd8);
    dly_cfg = '1;
    do_reset();
    clear_marks();
    for (int k = 0; k < 1100 && done_edge < 0; k++) cycle();
    chk("ff_rise0", 32'(rise[0]), 32'd260);
    chk("ff_done_edge", 32'(done_edge), 32'd1028);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4: number of sequenced reset domains (1..16).
REQ-002 Parameter CNT_W, default 8: width of each per-domain delay field and of the internal counter.
REQ-003 Parameter HOLD_CYC, default 16: cycles all domains stay in reset before sequencing starts (1..2^CNT_W).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 dly_cfg  in  NUM_DOM*CNT_W  per-domain release delay; field i is bits [i*CNT_W +: CNT_W].
REQ-007 sw_rst_req  in  1  software reset request, level-sampled each cycle.
REQ-008 sw_rst_ack  out  1  single-cycle pulse when a request is accepted.
REQ-009 rst_n_o  out  NUM_DOM  active-low domain resets; bit 0 is released first.
REQ-010 busy  out  1  high in ASSERT or RELEASE.
REQ-011 done  out  1  high in DONE (all domains released).

Function
REQ-012 The FSM SHALL have exactly three states: ASSERT, RELEASE, DONE.
REQ-013 ASSERT SHALL drive rst_n_o all-zero and last exactly HOLD_CYC cycles, with the counter running 0..HOLD_CYC-1.
REQ-014 On the final ASSERT cycle, the block SHALL capture dly_cfg into a shadow register, clear the counter and the domain index, and enter RELEASE.
REQ-015 dly_cfg changes after capture SHALL NOT affect the sequence in progress.
REQ-016 In RELEASE, stage i SHALL last shadow_dly[i]+1 cycles.
REQ-017 On the edge ending stage i, rst_n_o[i] SHALL go to 1, the counter SHALL clear, and the index SHALL increment.
REQ-018 A delay field of 0 SHALL give a 1-cycle stage.
REQ-019 Once released, a domain SHALL stay released until the next ASSERT; rst_n_o[j>i] SHALL stay 0 until its own stage ends.
REQ-020 The edge ending stage NUM_DOM-1 SHALL also enter DONE; the last rst_n_o bit and done SHALL rise on that same edge.
REQ-021 DONE SHALL hold rst_n_o all-ones until a request is accepted.
REQ-022 sw_rst_req sampled high in DONE or RELEASE SHALL be accepted, with these effects on the next edge:
  - state := ASSERT, counter := 0;
  - rst_n_o := all zero (released domains re-asserted);
  - sw_rst_ack pulses high for one cycle.
REQ-023 sw_rst_req during ASSERT SHALL be ignored: no ack, no counter restart.
REQ-024 A request held high SHALL be accepted once per pass through DONE or RELEASE; repeated acks only after ASSERT completes again.
REQ-025 The counter SHALL be CNT_W+1 bits wide so that HOLD_CYC = 2^CNT_W does not wrap; comparisons SHALL be unsigned.
REQ-026 busy SHALL equal NOT done at all times.

Reset
REQ-027 arst_n low SHALL asynchronously force:
  - rst_n_o = 0, counter = 0, index = 0, state = ASSERT;
  - sw_rst_ack = 0, busy = 1, done = 0.
REQ-028 Reset SHALL act at any point mid-sequence; deassertion SHALL restart a full ASSERT of HOLD_CYC cycles.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
Bench setup: NUM_DOM=4, CNT_W=8, HOLD_CYC=4; the first rising edge after arst_n deasserts is edge 1.
REQ-030 Power-up with dly_cfg={3:1,2:3,1:0,0:2} -> rst_n_o[0] rises at edge 7, [1] at 8, [2] at 12, [3] at 14; done=1 at edge 14.
REQ-031 Same config; dly_cfg changed to all 0xFF at edge 6 -> release timing identical to REQ-030.
REQ-032 In DONE, 1-cycle sw_rst_req -> next edge rst_n_o=4'b0000, sw_rst_ack=1 for one cycle, busy=1; sequence then repeats the REQ-030 offsets.
REQ-033 sw_rst_req held high continuously from DONE -> exactly one ack per ASSERT entry; rst_n_o[0] never stays high longer than one stage; done never asserts.
REQ-034 sw_rst_req pulsed at ASSERT counter=2 -> no ack, ASSERT still ends after 4 cycles total.
REQ-035 arst_n pulsed low after rst_n_o[1] rises -> all outputs reset immediately; after release, full 4-cycle ASSERT then the REQ-030 sequence; dly=0xFF on all domains gives done at edge 4+4*256=1028.
